usb_tx_packer: RTL and testbench

Byte-to-word packetizing buffer directly upstream of the USB transmit top level. It accepts result bytes from the miner core and packs byte pairs into 16-bit words. Words are held in a word FIFO with a per-word end-of-packet flag. The block drives the transmitter's `tx_data` / `transmit_empty` / `transmit_start` inputs and consumes its `read_enable` and `tx_error` outputs.

---
 rtl/usb_tx_pkg.sv | 14 +
 rtl/usb_tx_word_fifo.sv | 62 ++++++
 rtl/usb_tx_packer.sv | 135 +++++++++++++
 tb/tb_usb_tx_packer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit packetizing buffer.
package usb_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SEND  = 2'd2,
        FLUSH = 2'd3
    } tx_pkt_state_t;

    localparam logic [7:0] PAD_BYTE     = 8'h00;
    localparam int         USB_TX_DEPTH = 8;

endpackage

// File: rtl/usb_tx_word_fifo.sv
// Show-ahead word FIFO: head entry visible combinationally from the read pointer.
// Push while full and pop while empty are ignored; occupancy is exported as a count.
module usb_tx_word_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_dat_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_dat_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    assign full       = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign head_dat_o = mem_q[rd_ptr_q];
    assign push_ok    = push_i && !full;
    assign pop_ok     = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/usb_tx_packer.sv
// Packs miner result bytes into 16-bit words with end-of-packet flags and
// sequences whole packets into the USB transmitter (start pulse, pops, error flush).
module usb_tx_packer
    import usb_tx_pkg::*;
#(
    parameter int DEPTH = USB_TX_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    input  logic        wr_last,
    output logic        wr_ready,
    output logic        overflow,
    output logic [15:0] tx_data,
    output logic        transmit_empty,
    output logic        transmit_start,
    input  logic        read_enable,
    input  logic        tx_error
);

    localparam int CW = $clog2(DEPTH) + 1;

    tx_pkt_state_t state_q;
    logic [7:0]    lo_byte_q, lo_byte_d;
    logic          lo_valid_q, lo_valid_d;
    logic          overflow_q;
    logic [CW-1:0] pkt_count_q;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic [16:0]   head_word;
    logic [16:0]   push_word;
    logic          push;
    logic          pop;
    logic          pop_last;
    logic          accept;

    assign wr_ready       = (fifo_count != CW'(DEPTH));
    assign overflow       = overflow_q;
    assign transmit_empty = fifo_empty;
    assign tx_data        = fifo_empty ? 16'h0000 : head_word[15:0];
    assign accept         = wr_en && wr_ready;

    always_comb begin
        push       = 1'b0;
        push_word  = '0;
        lo_byte_d  = lo_byte_q;
        lo_valid_d = lo_valid_q;
        if (accept) begin
            if (lo_valid_q) begin
                push       = 1'b1;
                push_word  = {wr_last, wr_data, lo_byte_q};
                lo_valid_d = 1'b0;
            end else if (wr_last) begin
                push      = 1'b1;
                push_word = {1'b1, PAD_BYTE, wr_data};
            end else begin
                lo_byte_d  = wr_data;
                lo_valid_d = 1'b1;
            end
        end
    end

    // An error in SEND wins over a same-cycle pop so the flush still finds the packet tail.
    assign pop      = !fifo_empty &&
                      ((state_q == FLUSH) ||
                       ((state_q == SEND) && read_enable && !tx_error));
    assign pop_last = pop && head_word[16];

    usb_tx_word_fifo #(
        .WIDTH (17),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_dat_i (push_word),
        .pop_i      (pop),
        .head_dat_o (head_word),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            lo_byte_q   <= '0;
            lo_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            pkt_count_q <= '0;
        end else begin
            lo_byte_q  <= lo_byte_d;
            lo_valid_q <= lo_valid_d;
            if (wr_en && !wr_ready) begin
                overflow_q <= 1'b1;
            end
            case ({push && push_word[16], pop_last})
                2'b10:   pkt_count_q <= pkt_count_q + 1'b1;
                2'b01:   pkt_count_q <= pkt_count_q - 1'b1;
                default: pkt_count_q <= pkt_count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            transmit_start <= 1'b0;
        end else begin
            transmit_start <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pkt_count_q != '0) begin
                        state_q        <= START;
                        transmit_start <= 1'b1;
                    end
                end
                START: state_q <= SEND;
                SEND: begin
                    if (tx_error) begin
                        state_q <= FLUSH;
                    end else if (pop_last) begin
                        state_q <= IDLE;
                    end
                end
                FLUSH: begin
                    if (pop_last) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_tx_packer.sv
// Scoreboard bench for usb_tx_packer: a byte-packing model queues expected words,
// which are compared against tx_data whenever the bench pops the head.
module tb_usb_tx_packer;
    import usb_tx_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        wr_last;
    logic        wr_ready;
    logic        overflow;
    logic [15:0] tx_data;
    logic        transmit_empty;
    logic        transmit_start;
    logic        read_enable;
    logic        tx_error;

    usb_tx_packer #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .wr_en          (wr_en),
        .wr_data        (wr_data),
        .wr_last        (wr_last),
        .wr_ready       (wr_ready),
        .overflow       (overflow),
        .tx_data        (tx_data),
        .transmit_empty (transmit_empty),
        .transmit_start (transmit_start),
        .read_enable    (read_enable),
        .tx_error       (tx_error)
    );

    always #5 clk = ~clk;

    int          checks    = 0;
    int          failures  = 0;
    int          start_cnt = 0;
    int          start_base;
    logic [16:0] sb [$];
    bit          lo_v;
    logic [7:0]  lo_b;
    bit          ovf_m;

    always @(negedge clk) begin
        if (transmit_start === 1'b1) start_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One bus cycle: optional byte write and optional pop, with the model updated alongside.
    task automatic cyc(input bit we, input logic [7:0] b, input bit last, input bit re);
        bit          acc;
        logic [16:0] w;
        acc         = we && (sb.size() < DEPTH);
        wr_en       = we;
        wr_data     = b;
        wr_last     = last;
        read_enable = re;
        if (re && sb.size() > 0) begin
            w = sb.pop_front();
            check_eq("pop_head", 32'(tx_data), 32'(w[15:0]));
        end
        if (we && !acc) ovf_m = 1'b1;
        if (acc) begin
            if (lo_v) begin
                sb.push_back({last, b, lo_b});
                lo_v = 1'b0;
            end else if (last) begin
                sb.push_back({1'b1, 8'h00, b});
            end else begin
                lo_b = b;
                lo_v = 1'b1;
            end
        end
        tick();
        wr_en       = 1'b0;
        wr_last     = 1'b0;
        read_enable = 1'b0;
    endtask

    task automatic wait_send();
        for (int i = 0; i < 20 && dut.state_q != SEND; i++) tick();
        check_eq("wait_send", 32'(dut.state_q), 32'(SEND));
    endtask

    task automatic pop_pkt();
        logic [16:0] w;
        for (int i = 0; i < DEPTH + 2; i++) begin
            if (sb.size() == 0) begin
                check_eq("pkt_model_underrun", 0, 1);
                break;
            end
            w = sb[0];
            cyc(1'b0, 8'h00, 1'b0, 1'b1);
            if (w[16]) break;
        end
        check_eq("pkt_end_idle", 32'(dut.state_q), 32'(IDLE));
    endtask

    task automatic drain_pkt();
        wait_send();
        pop_pkt();
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_tx_data"}, 32'(tx_data), 'h0000);
        check_eq({pfx, "_empty"}, 32'(transmit_empty), 1);
        check_eq({pfx, "_start"}, 32'(transmit_start), 0);
        check_eq({pfx, "_wr_ready"}, 32'(wr_ready), 1);
        check_eq({pfx, "_overflow"}, 32'(overflow), 0);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; wr_last = 1'b0;
        read_enable = 1'b0; tx_error = 1'b0;
        lo_v = 1'b0; lo_b = 8'h00; ovf_m = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check_reset_outputs("rst");

        // Even packet with start-pulse timing.
        start_base = start_cnt;
        cyc(1, 8'hD2, 0, 0);
        cyc(1, 8'h54, 0, 0);
        check_eq("t1_head", 32'(tx_data), 'h54D2);
        cyc(1, 8'hC4, 0, 0);
        cyc(1, 8'hB3, 1, 0);
        check_eq("t1_start_n", 32'(transmit_start), 0);
        tick();
        check_eq("t1_start_n1", 32'(transmit_start), 1);
        tick();
        check_eq("t1_start_n2", 32'(transmit_start), 0);
        check_eq("t1_start_cnt", 32'(start_cnt - start_base), 1);
        pop_pkt();
        check_eq("t1_empty", 32'(transmit_empty), 1);
        check_eq("t1_tx_zero", 32'(tx_data), 'h0000);

        // Odd packet gets a padded final word.
        cyc(1, 8'h91, 0, 0);
        cyc(1, 8'hE6, 0, 0);
        cyc(1, 8'h38, 1, 0);
        drain_pkt();
        check_eq("t2_empty", 32'(transmit_empty), 1);

        // Fill to full, drop writes, then pop and refill.
        for (int i = 0; i < 16; i++) cyc(1, 8'(8'h10 + i), (i == 15), 0);
        check_eq("t3_full_ready", 32'(wr_ready), 0);
        cyc(1, 8'hAA, 0, 0);
        cyc(1, 8'hBB, 0, 0);
        check_eq("t3_overflow", 32'(overflow), 32'(ovf_m));
        check_eq("t3_still_full", 32'(wr_ready), 0);
        check_eq("t3_state_send", 32'(dut.state_q), 32'(SEND));
        cyc(1, 8'hCC, 0, 1);
        check_eq("t3_ready_after_pop", 32'(wr_ready), 1);
        cyc(1, 8'hDD, 0, 0);
        cyc(1, 8'hEE, 1, 1);
        check_eq("t3_push_pop_ready", 32'(wr_ready), 1);
        cyc(1, 8'hF0, 0, 0);
        cyc(1, 8'hF1, 1, 0);
        check_eq("t3_refull", 32'(wr_ready), 0);
        pop_pkt();
        drain_pkt();
        drain_pkt();
        check_eq("t3_empty", 32'(transmit_empty), 1);

        // Error mid-packet flushes only the rest of that packet.
        start_base = start_cnt;
        cyc(1, 8'hA1, 0, 0); cyc(1, 8'hA2, 0, 0); cyc(1, 8'hA3, 0, 0); cyc(1, 8'hA4, 1, 0);
        cyc(1, 8'hB1, 0, 0); cyc(1, 8'hB2, 0, 0); cyc(1, 8'hB3, 0, 0); cyc(1, 8'hB4, 1, 0);
        wait_send();
        cyc(0, 8'h00, 0, 1);
        tx_error = 1'b1;
        tick();
        tx_error = 1'b0;
        check_eq("t4_flush_state", 32'(dut.state_q), 32'(FLUSH));
        tick();
        void'(sb.pop_front());
        check_eq("t4_flush_1cyc", 32'(dut.state_q), 32'(IDLE));
        check_eq("t4_pkt2_head", 32'(tx_data), 'hB2B1);
        drain_pkt();
        check_eq("t4_start_cnt", 32'(start_cnt - start_base), 2);

        // Reset with a half-packed word pending.
        cyc(1, 8'h11, 0, 0);
        cyc(1, 8'h22, 1, 0);
        cyc(1, 8'h33, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete(); lo_v = 1'b0; ovf_m = 1'b0;
        check_reset_outputs("mid_rst");
        start_base = start_cnt;
        cyc(1, 8'h44, 0, 0);
        cyc(1, 8'h55, 1, 0);
        check_eq("t5_clean_pack", 32'(tx_data), 'h5544);
        drain_pkt();
        check_eq("t5_start_cnt", 32'(start_cnt - start_base), 1);

        // Reads against an empty FIFO do nothing.
        for (int i = 0; i < 3; i++) cyc(0, 8'h00, 0, 1);
        check_eq("t6_tx_zero", 32'(tx_data), 'h0000);
        check_eq("t6_empty", 32'(transmit_empty), 1);
        check_eq("t6_idle", 32'(dut.state_q), 32'(IDLE));
        check_eq("t6_ready", 32'(wr_ready), 1);
        check_eq("final_overflow", 32'(overflow), 32'(ovf_m));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
